unidade_controle_mc: RTL and testbench
======================================

Name: unidade_controle_mc

Overview:
- Multicycle MIPS main control FSM. Sits directly upstream of the ALU-control decoder.
- Decodes the IR opcode and sequences fetch/decode/execute/memory/writeback.
- Drives every datapath enable and mux select, including the 2-bit alu_op consumed by the ALU-control decoder.
- The funct field bypasses this block and goes straight to the ALU-control decoder.

Parameters:
- MEM_WAIT, 1, extra cycles a memory read needs before data is valid. Legal range 0..7.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26], stable from DECODE onward
- zero  input  1  ALU zero flag
- pc_en  output  1  PC load enable
- iord  output  1  0=PC address, 1=ALUOut address
- mem_wr  output  1  memory write strobe
- ir_write / mdr_write / a_write / b_write / aluout_write  output  1 each  register load enables
- reg_write  output  1  register-file write
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  2  00=ALUOut, 01=MDR, 10={imm,16'h0}
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=4, 10=signext, 11=signext<<2
- alu_op  output  2  00=add, 01=sub, 10=use funct; 11 never driven
- pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
- erro  output  1  sticky invalid-opcode flag
- estado  output  4  current state code, debug

Behaviour:
- Moore FSM. Outputs are decoded from the state register and wait counter only. Exception: pc_en in BRANCH also uses zero.
- Async reset: state=RST, wait_cnt=0, erro=0. Every output is 0 immediately, including mid-operation.
- Unlisted outputs are 0 in each state.
- RST (1 cycle) -> FETCH.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - wait_cnt counts 0..MEM_WAIT.
  - On the cycle where wait_cnt==MEM_WAIT: ir_write=1, pc_en=1 (pc_source=00), then -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, a_write=b_write=aluout_write=1. Next state by opcode:
  - 00 -> EXEC_R
  - 23/2B -> ADDR
  - 04 -> BRANCH
  - 02 -> JUMP
  - 0F -> LUI
  - any other -> INVALID
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, aluout_write=1 -> WB_R.
- WB_R: reg_dst=1, mem_to_reg=00, reg_write=1 -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, aluout_write=1 -> MEM_RD (opcode 23) or MEM_WR (opcode 2B).
- MEM_RD: iord=1, wait_cnt counts as in FETCH. Final cycle: mdr_write=1 -> WB_MEM.
- WB_MEM: reg_dst=0, mem_to_reg=01, reg_write=1 -> FETCH.
- MEM_WR: iord=1, mem_wr=1 for exactly one cycle -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- LUI: reg_dst=0, mem_to_reg=10, reg_write=1 -> FETCH.
- INVALID: erro<=1, all enables 0. Stays until reset.
- wait_cnt is cleared on every exit from FETCH/MEM_RD. Counter width is max(1, clog2(MEM_WAIT+1)).
- With MEM_WAIT=0, FETCH and MEM_RD last 1 cycle.

Optional Feature:
- Macro: UNIDADE_CONTROLE_BNE_EN.
- Defined: opcode 05 (bne) -> BRANCH. In BRANCH, pc_en=zero for beq and pc_en=!zero for bne; the distinction comes from an internal flag latched in DECODE.
- Undefined: opcode 05 -> INVALID.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4-bit, codes RST=0 .. INVALID=13)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_LUI
  - ALUOP_ADD/ALUOP_SUB/ALUOP_FUNCT, which are shared with the ALU-control decoder
  - mux-select constants for alu_src_b, mem_to_reg, pc_source
- One sub-module, contador_espera: wait counter with clear, enable and done=(cnt==MEM_WAIT).

Test Plan (MEM_WAIT=1):
- Reset asserted mid-MEM_RD -> same-cycle estado=0, all outputs 0. First FETCH follows 1 cycle after release.
- R-type (opcode 00) -> 5 cycles FETCH,FETCH,DECODE,EXEC_R,WB_R. alu_op=10 only in EXEC_R; reg_write=1, reg_dst=1 only in WB_R.
- lw (23) then sw (2B) -> lw takes 7 cycles with mdr_write on cycle 6 and mem_to_reg=01 on cycle 7. sw takes 5 cycles with a single mem_wr pulse and iord=1.
- beq (04) with zero=1 then zero=0 -> 4 cycles each. pc_en=1 in BRANCH only when zero=1; alu_op=01, pc_source=01.
- j (02) and lui (0F) -> 4 cycles each. j: pc_source=10, pc_en=1. lui: mem_to_reg=10, reg_write=1.
- Opcode 3F, and 05 without the macro -> INVALID, erro=1 held for 20 cycles with no enables. With UNIDADE_CONTROLE_BNE_EN, 05 with zero=0 -> pc_en=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM state codes, opcodes and mux-select constants for the multicycle control
// Shared by unidade_controle_mc and the downstream ALU-control decoder (ALUOP_* constants).
// Build option: define UNIDADE_CONTROLE_BNE_EN to decode bne (opcode 05) as a branch.
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_WB_R    = 4'd4,
        S_ADDR    = 4'd5,
        S_MEM_RD  = 4'd6,
        S_WB_MEM  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_LUI     = 4'd11,
        S_INVALID = 4'd13
    } estado_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_4       = 2'b01;
    localparam logic [1:0] ASB_SEXT    = 2'b10;
    localparam logic [1:0] ASB_SEXT_SH = 2'b11;
    localparam logic [1:0] MTR_ALUOUT  = 2'b00;
    localparam logic [1:0] MTR_MDR     = 2'b01;
    localparam logic [1:0] MTR_LUI     = 2'b10;
    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP    = 2'b10;
    // State that follows DECODE for a given opcode.
    function automatic estado_t decode_next(input logic [5:0] op);
        decode_next = (op == OP_RTYPE)            ? S_EXEC_R :
                      (op == OP_LW || op == OP_SW) ? S_ADDR   :
                      (op == OP_BEQ)              ? S_BRANCH :
`ifdef UNIDADE_CONTROLE_BNE_EN
                      (op == OP_BNE)              ? S_BRANCH :
`endif
                      (op == OP_J)                ? S_JUMP   :
                      (op == OP_LUI)              ? S_LUI    : S_INVALID;
    endfunction
endpackage

// File: rtl/contador_espera.sv
// contador_espera: memory wait counter, counts 0..MEM_WAIT and flags the final cycle
// Ports: clock, reset (async, active-high), clr (sync clear, wins over en), en (count),
//        done (high while the count equals MEM_WAIT).
module contador_espera #(
    parameter int MEM_WAIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign done = (cnt == W'(MEM_WAIT));
endmodule

// File: rtl/unidade_controle_mc.sv
// unidade_controle_mc: multicycle MIPS main control FSM (Moore) driving datapath enables and mux selects
// Inputs : clock, reset (async, active-high), opcode (IR[31:26]), zero (ALU flag).
// Outputs: pc_en, iord, mem_wr, ir_write, mdr_write, a_write, b_write, aluout_write, reg_write,
//          reg_dst, mem_to_reg[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0],
//          erro (sticky invalid opcode), estado[3:0] (current state code).
// Build option: define UNIDADE_CONTROLE_BNE_EN to accept bne (opcode 05).
module unidade_controle_mc
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       erro,
    output logic [3:0] estado
);
    estado_t state, next;
    logic    wait_done, wait_en, bne_flag;
    assign wait_en = (state == S_FETCH) || (state == S_MEM_RD);
    // Clearing whenever not waiting guarantees every FETCH/MEM_RD starts from zero.
    contador_espera #(.MEM_WAIT(MEM_WAIT)) u_espera (
        .clock(clock),
        .reset(reset),
        .clr  (!wait_en || wait_done),
        .en   (wait_en),
        .done (wait_done)
    );
    always_comb begin
        next = state;
        case (state)
            S_RST:    next = S_FETCH;
            S_FETCH:  next = wait_done ? S_DECODE : S_FETCH;
            S_DECODE: next = decode_next(opcode);
            S_EXEC_R: next = S_WB_R;
            S_ADDR:   next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: next = wait_done ? S_WB_MEM : S_MEM_RD;
            S_INVALID: next = S_INVALID;
            default:  next = S_FETCH;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_RST;
            erro     <= 1'b0;
            bne_flag <= 1'b0;
        end else begin
            state <= next;
            if (state == S_INVALID) erro <= 1'b1;
`ifdef UNIDADE_CONTROLE_BNE_EN
            if (state == S_DECODE) bne_flag <= (opcode == OP_BNE);
`endif
        end
    end
    always_comb begin
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_wr       = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = MTR_ALUOUT;
        alu_src_a    = 1'b0;
        alu_src_b    = ASB_B;
        alu_op       = ALUOP_ADD;
        pc_source    = PCS_ALU;
        case (state)
            S_FETCH: begin
                alu_src_b = ASB_4;
                ir_write  = wait_done;
                pc_en     = wait_done;
            end
            S_DECODE: begin
                alu_src_b    = ASB_SEXT_SH;
                a_write      = 1'b1;
                b_write      = 1'b1;
                aluout_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_op       = ALUOP_FUNCT;
                aluout_write = 1'b1;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = ASB_SEXT;
                aluout_write = 1'b1;
            end
            S_MEM_RD: begin
                iord      = 1'b1;
                mdr_write = wait_done;
            end
            S_WB_MEM: begin
                mem_to_reg = MTR_MDR;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCS_ALUOUT;
                // bne_flag stays 0 unless bne support is built in, giving plain beq.
                pc_en     = zero ^ bne_flag;
            end
            S_JUMP: begin
                pc_source = PCS_JUMP;
                pc_en     = 1'b1;
            end
            S_LUI: begin
                mem_to_reg = MTR_LUI;
                reg_write  = 1'b1;
            end
            default: ;
        endcase
    end
    assign estado = state;
endmodule

// File: tb/tb_unidade_controle_mc.sv
// tb_unidade_controle_mc: directed checks of the multicycle control FSM with MEM_WAIT=1
module tb_unidade_controle_mc;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       pc_en, iord, mem_wr, ir_write, mdr_write, a_write, b_write, aluout_write;
    logic       reg_write, reg_dst, alu_src_a, erro;
    logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] estado;
    int         errors = 0;
    int         checks = 0;

    unidade_controle_mc #(.MEM_WAIT(1)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_wr(mem_wr), .ir_write(ir_write),
        .mdr_write(mdr_write), .a_write(a_write), .b_write(b_write),
        .aluout_write(aluout_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .erro(erro), .estado(estado)
    );

    always #5 clock = ~clock;

    // {pc_en,iord,mem_wr,ir_write,mdr_write,a_write,b_write,aluout_write,reg_write,reg_dst,
    //  mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_source,erro,estado}
    wire [23:0] obs = {pc_en, iord, mem_wr, ir_write, mdr_write, a_write, b_write, aluout_write,
                       reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                       erro, estado};

    localparam logic [23:0] E_RST  = 24'h0;
    localparam logic [23:0] E_F0   = {10'b0000000000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd1};
    localparam logic [23:0] E_F1   = {10'b1001000000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd1};
    localparam logic [23:0] E_DEC  = {10'b0000011100, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 4'd2};
    localparam logic [23:0] E_EXR  = {10'b0000000100, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 4'd3};
    localparam logic [23:0] E_WBR  = {10'b0000000011, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd4};
    localparam logic [23:0] E_ADDR = {10'b0000000100, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 4'd5};
    localparam logic [23:0] E_MR0  = {10'b0100000000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd6};
    localparam logic [23:0] E_MR1  = {10'b0100100000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd6};
    localparam logic [23:0] E_WBM  = {10'b0000000010, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd7};
    localparam logic [23:0] E_MW   = {10'b0110000000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd8};
    localparam logic [23:0] E_BR1  = {10'b1000000000, 2'b00, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 4'd9};
    localparam logic [23:0] E_BR0  = {10'b0000000000, 2'b00, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 4'd9};
    localparam logic [23:0] E_J    = {10'b1000000000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 4'd10};
    localparam logic [23:0] E_LUI  = {10'b0000000010, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd11};
    localparam logic [23:0] E_INV0 = {10'b0000000000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd13};
    localparam logic [23:0] E_INV  = {10'b0000000000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 4'd13};

    task automatic chk(input string tag, input logic [23:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic cyc(input string tag, input logic [23:0] e);
        @(posedge clock);
        #1;
        chk(tag, e);
    endtask

    task automatic fetch_decode(input string tag);
        cyc({tag, "_f0"}, E_F0);
        cyc({tag, "_f1"}, E_F1);
        cyc({tag, "_dec"}, E_DEC);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset", E_RST);
        reset = 1'b0;
        // R-type
        opcode = 6'h00;
        fetch_decode("r");
        cyc("r_exec", E_EXR);
        cyc("r_wb", E_WBR);
        // lw
        opcode = 6'h23;
        fetch_decode("lw");
        cyc("lw_addr", E_ADDR);
        cyc("lw_rd0", E_MR0);
        cyc("lw_rd1", E_MR1);
        cyc("lw_wb", E_WBM);
        // sw
        opcode = 6'h2B;
        fetch_decode("sw");
        cyc("sw_addr", E_ADDR);
        cyc("sw_wr", E_MW);
        cyc("sw_after", E_F0);
        cyc("sw_after1", E_F1);
        // beq taken, then not taken (fetch of this one already started)
        opcode = 6'h04;
        zero = 1'b1;
        cyc("beq1_dec", E_DEC);
        cyc("beq1_br", E_BR1);
        zero = 1'b0;
        fetch_decode("beq0");
        cyc("beq0_br", E_BR0);
        // j and lui
        opcode = 6'h02;
        fetch_decode("j");
        cyc("j_jump", E_J);
        opcode = 6'h0F;
        fetch_decode("lui");
        cyc("lui_wb", E_LUI);
        // reset asserted in the middle of a memory read
        opcode = 6'h23;
        fetch_decode("lwr");
        cyc("lwr_addr", E_ADDR);
        cyc("lwr_rd0", E_MR0);
        #3 reset = 1'b1;
        #1;
        chk("rst_async", E_RST);
        cyc("rst_hold", E_RST);
        reset = 1'b0;
        opcode = 6'h00;
        cyc("rst_fetch", E_F0);
        // invalid opcode 3F: erro sticky, no enables
        opcode = 6'h3F;
        cyc("inv_f1", E_F1);
        cyc("inv_dec", E_DEC);
        cyc("inv_enter", E_INV0);
        opcode = 6'h00;
        for (int i = 0; i < 20; i++) cyc("inv_hold", E_INV);
        reset = 1'b1;
        #1;
        chk("inv_rst", E_RST);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // opcode 05: bne when built in, otherwise invalid
        opcode = 6'h05;
        zero = 1'b0;
        fetch_decode("bne");
`ifdef UNIDADE_CONTROLE_BNE_EN
        cyc("bne_br", E_BR1);
        zero = 1'b1;
        fetch_decode("bne_z");
        cyc("bne_z_br", E_BR0);
`else
        cyc("bne_inv0", E_INV0);
        for (int i = 0; i < 20; i++) cyc("bne_inv", E_INV);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
